// File: rtl/int_controller_pkg.sv
// int_controller_pkg: register map, FSM states and STAT layout for the interrupt controller
package int_controller_pkg;
    localparam logic [2:0] INTC_CTRL  = 3'd0;
    localparam logic [2:0] INTC_MASK  = 3'd1;
    localparam logic [2:0] INTC_PEND  = 3'd2;
    localparam logic [2:0] INTC_VBASE = 3'd3;
    localparam logic [2:0] INTC_STAT  = 3'd4;
    localparam int STAT_SVC_BIT = 7;
    localparam int STAT_IDX_MSB = 2;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_SERVICE
    } state_e;
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-wins priority encoder
module int_prio_enc #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req_i,
    output logic             any_o,
    output logic [2:0]       idx_o
);
    always_comb begin
        idx_o = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (req_i[i]) idx_o = 3'(i);
        any_o = |req_i;
    end
endmodule

// File: rtl/int_controller.sv
// int_controller: edge-latching masked priority interrupt controller with a register window
module int_controller
    import int_controller_pkg::*;
#(
    parameter int         N_SRC        = 4,
    parameter int         VEC_SHIFT    = 2,
    parameter logic [7:0] VEC_BASE_RST = 8'h80
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             cpu_ret,
    input  logic             cfg_w_en,
    input  logic [2:0]       cfg_addr,
    input  logic [7:0]       cfg_w_data,
    output logic [7:0]       cfg_r_data,
    output logic             int_req,
    output logic [7:0]       int_en,
    output logic [7:0]       int_vec
);
    state_e state_q, state_d;
    logic gie_q, gie_d;
    logic [N_SRC-1:0] mask_q, mask_d, pend_q, pend_d, src_prev_q, clr;
    logic [7:0] vbase_q, vbase_d, vec_q, vec_d, stat;
    logic [2:0] act_idx_q, act_idx_d, idx;
    logic any, disp;

    int_prio_enc #(.N_SRC(N_SRC)) u_enc (
        .req_i(pend_q & mask_q),
        .any_o(any),
        .idx_o(idx)
    );

    always_comb begin
        disp = state_q == ST_IDLE && gie_q && any;
        clr = (cfg_w_en && cfg_addr == INTC_PEND ? cfg_w_data[N_SRC-1:0] : '0)
            | (disp ? N_SRC'(1) << idx : '0);
        // a fresh edge beats any clear landing on the same bit
        pend_d = (pend_q & ~clr) | (src_irq & ~src_prev_q);
        state_d = disp ? ST_DISPATCH
                : state_q == ST_DISPATCH ? ST_SERVICE
                : state_q == ST_SERVICE && cpu_ret ? ST_IDLE
                : state_q;
        act_idx_d = disp ? idx : act_idx_q;
        vec_d = disp ? vbase_q + 8'({5'b0, idx} << VEC_SHIFT) : vec_q;
        gie_d = cfg_w_en && cfg_addr == INTC_CTRL ? cfg_w_data[0] : gie_q;
        mask_d = cfg_w_en && cfg_addr == INTC_MASK ? cfg_w_data[N_SRC-1:0] : mask_q;
        vbase_d = cfg_w_en && cfg_addr == INTC_VBASE ? cfg_w_data : vbase_q;
        stat = '0;
        stat[STAT_SVC_BIT] = state_q == ST_SERVICE;
        stat[STAT_IDX_MSB:0] = act_idx_q;
        cfg_r_data = cfg_addr == INTC_CTRL  ? {7'b0, gie_q}
                   : cfg_addr == INTC_MASK  ? 8'(mask_q)
                   : cfg_addr == INTC_PEND  ? 8'(pend_q)
                   : cfg_addr == INTC_VBASE ? vbase_q
                   : cfg_addr == INTC_STAT  ? stat
                   : 8'h00;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gie_q      <= 1'b0;
            mask_q     <= '0;
            pend_q     <= '0;
            src_prev_q <= '0;
            vbase_q    <= VEC_BASE_RST;
            vec_q      <= '0;
            act_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            gie_q      <= gie_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            src_prev_q <= src_irq;
            vbase_q    <= vbase_d;
            vec_q      <= vec_d;
            act_idx_q  <= act_idx_d;
        end
    end

    assign int_req = state_q == ST_DISPATCH;
    assign int_en  = {7'b0, int_req};
    assign int_vec = vec_q;
endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed plus randomized checks against a behavioural interrupt model
module tb_int_controller;
    localparam int N = 4;
    localparam int VS = 2;

    logic clk = 0;
    logic rst_s = 1;
    logic [N-1:0] src_s = '0;
    logic ret_s = 0, wen_s = 0;
    logic [2:0] addr_s = '0;
    logic [7:0] wdata_s = '0;
    logic [7:0] cfg_r_data, int_en, int_vec;
    logic int_req;
    int cmp = 0, errs = 0;

    bit m_pend[N], m_mask[N], m_prev[N];
    bit m_gie;
    int m_phase, m_act, m_vbase, m_vec;

    always #5 clk = ~clk;

    int_controller dut (
        .clock(clk), .reset(rst_s), .src_irq(src_s), .cpu_ret(ret_s),
        .cfg_w_en(wen_s), .cfg_addr(addr_s), .cfg_w_data(wdata_s),
        .cfg_r_data(cfg_r_data), .int_req(int_req), .int_en(int_en), .int_vec(int_vec)
    );

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        cmp++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(logic [2:0] a);
        int v = 0;
        case (a)
            3'd0: v = int'(m_gie);
            3'd1: for (int i = 0; i < N; i++) v += int'(m_mask[i]) << i;
            3'd2: for (int i = 0; i < N; i++) v += int'(m_pend[i]) << i;
            3'd3: v = m_vbase;
            3'd4: v = (m_phase == 2 ? 128 : 0) + m_act;
            default: v = 0;
        endcase
        return 8'(v);
    endfunction

    task automatic model_step();
        int idx = -1;
        bit np[N];
        if (rst_s) begin
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_mask[i] = 0; m_prev[i] = 0; end
            m_gie = 0; m_phase = 0; m_act = 0; m_vbase = 'h80; m_vec = 0;
            return;
        end
        if (m_gie && m_phase == 0)
            for (int i = 0; i < N; i++) if (idx < 0 && m_pend[i] && m_mask[i]) idx = i;
        for (int i = 0; i < N; i++)
            np[i] = (src_s[i] && !m_prev[i]) ||
                    (m_pend[i] && !((wen_s && addr_s == 3'd2 && wdata_s[i]) || idx == i));
        if (idx >= 0) begin
            m_phase = 1; m_act = idx; m_vec = (m_vbase + idx * (1 << VS)) % 256;
        end else if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2 && ret_s) m_phase = 0;
        if (wen_s) begin
            if (addr_s == 3'd0) m_gie = wdata_s[0];
            if (addr_s == 3'd1) for (int i = 0; i < N; i++) m_mask[i] = wdata_s[i];
            if (addr_s == 3'd3) m_vbase = int'(wdata_s);
        end
        for (int i = 0; i < N; i++) begin m_pend[i] = np[i]; m_prev[i] = src_s[i]; end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("int_req", {7'b0, int_req}, {7'b0, m_phase == 1});
        chk("int_en", int_en, {7'b0, m_phase == 1});
        chk("int_vec", int_vec, 8'(m_vec));
        chk("cfg_r_data", cfg_r_data, exp_rd(addr_s));
    endtask

    task automatic wr(logic [2:0] a, logic [7:0] d);
        wen_s = 1; addr_s = a; wdata_s = d;
        tick();
        wen_s = 0;
    endtask

    initial begin
        tick(); tick();
        rst_s = 0;
        wr(3'd0, 8'h01); wr(3'd1, 8'h0F); wr(3'd3, 8'h80);
        src_s = 4'b0100; tick();
        chk("basic_no_req_yet", {7'b0, int_req}, 8'h00);
        tick();
        chk("basic_req", {7'b0, int_req}, 8'h01);
        chk("basic_vec", int_vec, 8'h88);
        chk("basic_en", int_en, 8'h01);
        src_s = 0; addr_s = 3'd4; tick();
        chk("basic_stat", cfg_r_data, 8'h82);
        addr_s = 3'd2; #1;
        chk("basic_pend", cfg_r_data, 8'h00);
        ret_s = 1; tick(); ret_s = 0;
        src_s = 4'b1010; tick(); tick();
        chk("prio_vec", int_vec, 8'h84);
        src_s = 0; tick();
        chk("prio_pend", cfg_r_data, 8'h08);
        addr_s = 3'd4; #1;
        chk("prio_stat", cfg_r_data, 8'h81);
        ret_s = 1; tick(); ret_s = 0;
        tick();
        chk("queued_req", {7'b0, int_req}, 8'h01);
        chk("queued_vec", int_vec, 8'h8C);
        tick(); ret_s = 1; tick(); ret_s = 0;
        wr(3'd1, 8'h00);
        src_s = 4'b0001; tick(); src_s = 0; tick(); tick();
        addr_s = 3'd2; #1;
        chk("masked_pend", cfg_r_data, 8'h01);
        wr(3'd1, 8'h01);
        tick();
        chk("unmask_req", {7'b0, int_req}, 8'h01);
        tick(); ret_s = 1; tick(); ret_s = 0;
        wr(3'd0, 8'h00);
        src_s = 4'b0001; tick(); src_s = 0;
        for (int i = 0; i < 3; i++) tick();
        wr(3'd0, 8'h01); tick();
        chk("gie_req", {7'b0, int_req}, 8'h01);
        tick(); ret_s = 1; tick(); ret_s = 0;
        wr(3'd1, 8'h00);
        src_s = 4'b0001; wr(3'd2, 8'h01); src_s = 0;
        chk("w1c_collide", cfg_r_data, 8'h01);
        wr(3'd2, 8'h01);
        chk("w1c_plain", cfg_r_data, 8'h00);
        wr(3'd3, 8'hFC); wr(3'd1, 8'h0F);
        src_s = 4'b0010; tick(); src_s = 0; tick();
        chk("wrap_vec", int_vec, 8'h00);
        tick(); ret_s = 1; tick(); ret_s = 0;
        ret_s = 1; tick(); ret_s = 0; tick();
        src_s = 4'b0111; tick(); src_s = 0; tick(); tick();
        addr_s = 3'd2; #1;
        chk("pre_reset_pend", cfg_r_data, 8'h06);
        rst_s = 1; tick(); rst_s = 0;
        chk("rst_req", {7'b0, int_req}, 8'h00);
        chk("rst_pend", cfg_r_data, 8'h00);
        addr_s = 3'd3; #1;
        chk("rst_vbase", cfg_r_data, 8'h80);
        addr_s = 3'd4; #1;
        chk("rst_stat", cfg_r_data, 8'h00);
        wr(3'd0, 8'h01); wr(3'd1, 8'h0F);
        for (int c = 0; c < 600; c++) begin
            src_s = src_s ^ (($urandom_range(0, 2) == 0) ? N'($urandom) : '0);
            ret_s = $urandom_range(0, 3) == 0;
            wen_s = $urandom_range(0, 5) == 0;
            addr_s = 3'($urandom_range(0, 7));
            wdata_s = 8'($urandom);
            if (wen_s && addr_s == 3'd0) wdata_s[0] = $urandom_range(0, 3) != 0;
            rst_s = $urandom_range(0, 99) == 0;
            tick();
            if (rst_s) begin rst_s = 0; wr(3'd0, 8'h01); wr(3'd1, 8'h0F); end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/int_controller.md
# int_controller

Priority interrupt controller for the 8-bit jacaranda-8 core. It latches rising edges on up to `N_SRC` peripheral interrupt lines and masks them. It then selects the lowest-index pending source and presents the CPU with a one-cycle `int_req`, the qualifying `int_en` and a computed `int_vec`. It blocks further dispatch until the handler's `ret` executes, and it is configured through a small memory-mapped register window on the data bus.

## Interface
Parameters:
- `N_SRC`, default 4: number of interrupt sources, range 1..7.
- `VEC_SHIFT`, default 2: vector spacing, where `int_vec = vec_base + (idx << VEC_SHIFT)`.
- `VEC_BASE_RST`, default 8'h80: reset value of `vec_base`.

Ports:
- `clock` in 1: system clock, the same net that clocks the CPU.
- `reset` in 1: **synchronous, active-high** reset.
- `src_irq` in N_SRC: peripheral interrupt lines; already synchronous to `clock`.
- `cpu_ret` in 1: one-cycle pulse when the CPU executes `ret`, from the main controller's `ret` decode.
- `cfg_w_en` in 1: register write strobe.
- `cfg_addr` in 3: register address.
- `cfg_w_data` in 8: write data.
- `cfg_r_data` out 8: combinational read data for `cfg_addr`.
- `int_req` out 1: interrupt request to the CPU.
- `int_en` out 8: interrupt enable to the CPU; bit0 qualifies `int_req` and bits 7:1 are always 0.
- `int_vec` out 8: handler address, stable whenever `int_req` is 1.

## Operation
Registers (addresses are in the package):
- 0 CTRL: bit0 `gie` (global enable), read/write.
- 1 MASK: bits N_SRC-1:0, read/write; 1 means enabled.
- 2 PEND: read gives pending bits; writing 1 to a bit clears it.
- 3 VBASE: `vec_base`, read/write.
- 4 STAT: read-only; bit7 = in service (SERVICE state), bits 2:0 = `act_idx`.
- Reads of other addresses return 0. Writes to other addresses or to read-only fields are ignored.

Edge capture:
- `src_prev` holds `src_irq` delayed one cycle.
- A rising edge (`src_irq & ~src_prev`) sets the corresponding PEND bit.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- A level held high does not re-trigger.

State machine:
- IDLE:
  - Condition: `gie` = 1 and `(PEND & MASK)` ≠ 0.
  - Action: `act_idx` ← lowest set index; clear that PEND bit.
  - Transition: go to DISPATCH.
- DISPATCH, always exactly one cycle:
  - `int_req` = 1 and `int_en[0]` = 1.
  - `int_vec = (vec_base + (act_idx << VEC_SHIFT)) mod 256`.
  - Transition: go to SERVICE.
- SERVICE:
  - Wait for `cpu_ret`, then go to IDLE.
  - Edges arriving meanwhile are only latched into PEND; there is no nesting.
- Outside DISPATCH: `int_req` = 0, `int_en` = 0, and `int_vec` holds its last value.
- `cpu_ret` in IDLE or DISPATCH is ignored.
- A write that clears `gie` does not abort DISPATCH or SERVICE. It only blocks the next IDLE→DISPATCH transition.
- MASK and VBASE writes are registered at the clock edge. An IDLE decision in the same cycle uses the old values.

## Timing
- Reset: all outputs and registers are 0, except `vec_base` = VEC_BASE_RST. State = IDLE and `src_prev` = 0.
- Reset during DISPATCH or SERVICE drops `int_req` in the next cycle. Pending edges are lost.
- Latency from the first edge at which `src_irq` is sampled high:
  - PEND is set after that edge.
  - DISPATCH is entered one edge later.
  - The CPU takes the vector at the following edge.
  - `int_req` is therefore high during exactly one cycle, starting 2 cycles after the source rose.
- Back-to-back interrupts: `cpu_ret` seen at edge k gives IDLE after k. The next DISPATCH comes no earlier than k+1.

## Structure
- Package `int_controller_pkg`:
  - Register addresses: `INTC_CTRL`, `INTC_MASK`, `INTC_PEND`, `INTC_VBASE`, `INTC_STAT`.
  - State encodings: `ST_IDLE`, `ST_DISPATCH`, `ST_SERVICE`.
  - STAT bit positions.
- One sub-module `int_prio_enc` (combinational, parameterised by N_SRC):
  - Input: `PEND & MASK`.
  - Outputs: `any` and the lowest set index `idx`.

## Test plan
- Basic dispatch:
  - Stimulus: reset; `gie` = 1, MASK = 4'b1111, VBASE = 8'h80; pulse `src_irq[2]`.
  - Response: `int_req` is high for one cycle, 2 cycles after the rise, with `int_vec` = 8'h88 and `int_en` = 8'h01. STAT reads 8'h82. PEND[2] = 0.
- Priority and queuing:
  - Stimulus: raise `src_irq[3]` and `src_irq[1]` together.
  - Response: index 1 is dispatched (`int_vec` = 8'h84). STAT shows service, and PEND reads 4'b1000.
  - Stimulus: pulse `cpu_ret`.
  - Response: index 3 is dispatched 2 cycles later (`int_vec` = 8'h8C).
- Mask and global enable:
  - Stimulus: MASK = 0; pulse `src_irq[0]`.
  - Response: no `int_req`; PEND = 4'b0001.
  - Stimulus: MASK = 1.
  - Response: dispatch follows.
  - Stimulus: with `gie` = 0 and a source pending.
  - Response: no `int_req` until `gie` is set to 1.
- W1C against edge collision:
  - Stimulus: in the same cycle, a PEND write of 8'h01 and a rising `src_irq[0]`.
  - Response: PEND[0] stays 1.
  - Stimulus: a plain W1C of 8'h01.
  - Response: PEND[0] clears.
- Vector wrap and stray return:
  - Stimulus: VBASE = 8'hFC, VEC_SHIFT = 2; dispatch `idx` 1.
  - Response: `int_vec` = 8'h00.
  - Stimulus: `cpu_ret` while IDLE.
  - Response: no state change.
- Reset mid-service:
  - Stimulus: assert `reset` while in SERVICE with PEND = 4'b0110.
  - Response: the next cycle has state IDLE, PEND = 0, `int_req` = 0, and VBASE = 8'h80.
